// File: rtl/frame_stream_reader_mb_if.sv
// Bus bundle for frame_stream_reader_mb: frame-descriptor input, burst-read
// request/data channel to the memory master, and the AXI-Stream pixel output.
interface frame_stream_reader_mb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  frame_ready;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [15:0]           frame_width;
  logic [15:0]           frame_height;

  logic                  start_read;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [31:0]           read_len;
  logic [2:0]            read_size;
  logic [1:0]            read_burst;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rlast;
  logic                  rready;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;

  modport master (
    input  frame_ready, base_addr, frame_width, frame_height,
    input  arready, rdata, rvalid, rlast, m_axis_tready,
    output start_read, read_addr, read_len, read_size, read_burst, rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport slave (
    output frame_ready, base_addr, frame_width, frame_height,
    output arready, rdata, rvalid, rlast, m_axis_tready,
    input  start_read, read_addr, read_len, read_size, read_burst, rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/frame_stream_reader_mb.sv
// Multi-buffer frame reader: queues frame descriptors, fetches each frame with
// credit-checked 4KB-safe INCR bursts, and streams raster pixels with tuser/tlast.
module frame_stream_reader_mb #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int BURST_LEN     = 16,
  parameter int FIFO_DEPTH    = 64,
  parameter int FRAME_Q_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  frame_stream_reader_mb_if.master bus,
  output logic busy,
  output logic queue_overflow,
  output logic rlast_error
);
  localparam int BSH = $clog2(DATA_WIDTH/8);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int QAW = $clog2(FRAME_Q_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base;
    logic [15:0]           w;
    logic [15:0]           h;
  } desc_t;
  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DATA} state_e;

  desc_t dq_mem [FRAME_Q_DEPTH];
  desc_t oq_mem [FRAME_Q_DEPTH];
  logic [DATA_WIDTH-1:0] pf_mem [FIFO_DEPTH];
  logic [QAW-1:0] dq_wp_q, dq_rp_q, oq_wp_q, oq_rp_q;
  logic [QAW:0]   dq_cnt_q, oq_cnt_q;
  logic [FAW-1:0] pf_wp_q, pf_rp_q;
  logic [FAW:0]   pf_cnt_q;

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] total_q, total_d, idx_q, idx_d, beats_q, beats_d, len_q, len_d, bcnt_q, bcnt_d;
  logic sent_q, sent_d, rerr_q, rerr_d, ovf_q;
  logic [15:0] row_q, col_q;

  logic dq_push, dq_pop, dq_full, oq_full, oq_pop, pf_push, pf_pop, in_ok, eol, eof;
  logic [31:0] free, rem4k, left, calc_beats;
  desc_t dq_head, oq_head;

  assign in_ok   = bus.frame_ready && (bus.frame_width != '0) && (bus.frame_height != '0);
  assign dq_full = dq_cnt_q == (QAW+1)'(FRAME_Q_DEPTH);
  assign oq_full = oq_cnt_q == (QAW+1)'(FRAME_Q_DEPTH);
  // A pop in the same cycle frees the slot, so a push on a full queue still lands
  assign dq_push = in_ok && (!dq_full || dq_pop);
  assign dq_head = dq_mem[dq_rp_q];
  assign oq_head = oq_mem[oq_rp_q];

  assign free  = 32'(FIFO_DEPTH) - 32'(pf_cnt_q);
  assign rem4k = (32'd4096 - {20'd0, addr_q[11:0]}) >> BSH;
  assign left  = total_q - idx_q;

  always_comb begin
    calc_beats = 32'(BURST_LEN);
    if (left < calc_beats)  calc_beats = left;
    if (rem4k < calc_beats) calc_beats = rem4k;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    total_d = total_q;
    idx_d   = idx_q;
    beats_d = beats_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    sent_d  = sent_q;
    rerr_d  = rerr_q;
    dq_pop  = 1'b0;
    pf_push = 1'b0;
    bus.start_read = 1'b0;
    bus.rready     = 1'b0;
    case (state_q)
      IDLE: if (dq_cnt_q != '0 && !oq_full) begin
        dq_pop  = 1'b1;
        addr_d  = dq_head.base;
        total_d = 32'(dq_head.w) * 32'(dq_head.h);
        idx_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        beats_d = calc_beats;
        len_d   = calc_beats - 32'd1;
        bcnt_d  = '0;
        sent_d  = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: begin
        bus.start_read = !sent_q && (free >= beats_q);
        if (bus.start_read) sent_d = 1'b1;
        if ((bus.start_read || sent_q) && bus.arready) state_d = DATA;
      end
      DATA: begin
        bus.rready = 1'b1;
        if (bus.rvalid) begin
          pf_push = 1'b1;
          // Beat count ends the burst; rlast is only cross-checked
          if (bus.rlast != (bcnt_q == beats_q - 32'd1)) rerr_d = 1'b1;
          if (bcnt_q == beats_q - 32'd1) begin
            addr_d  = addr_q + ADDR_WIDTH'(beats_q << BSH);
            idx_d   = idx_q + beats_q;
            state_d = (idx_q + beats_q < total_q) ? CALC : IDLE;
          end else begin
            bcnt_d = bcnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      total_q <= '0;
      idx_q   <= '0;
      beats_q <= '0;
      len_q   <= '0;
      bcnt_q  <= '0;
      sent_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      total_q <= total_d;
      idx_q   <= idx_d;
      beats_q <= beats_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      sent_q  <= sent_d;
      rerr_q  <= rerr_d;
    end
  end

  // Storage arrays carry no reset; pointers/counts define validity
  always_ff @(posedge clk) begin
    if (dq_push) dq_mem[dq_wp_q] <= '{bus.base_addr, bus.frame_width, bus.frame_height};
    if (dq_pop)  oq_mem[oq_wp_q] <= dq_head;
    if (pf_push) pf_mem[pf_wp_q] <= bus.rdata;
  end

  assign pf_pop = bus.m_axis_tvalid && bus.m_axis_tready;
  assign eol    = col_q == oq_head.w - 16'd1;
  assign eof    = eol && (row_q == oq_head.h - 16'd1);
  assign oq_pop = pf_pop && eof;

  always_ff @(posedge clk) begin
    if (rst) begin
      dq_wp_q <= '0; dq_rp_q <= '0; dq_cnt_q <= '0;
      oq_wp_q <= '0; oq_rp_q <= '0; oq_cnt_q <= '0;
      pf_wp_q <= '0; pf_rp_q <= '0; pf_cnt_q <= '0;
      row_q   <= '0; col_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (dq_push) dq_wp_q <= dq_wp_q + 1'b1;
      if (dq_pop)  dq_rp_q <= dq_rp_q + 1'b1;
      dq_cnt_q <= dq_cnt_q + (QAW+1)'(dq_push) - (QAW+1)'(dq_pop);
      if (in_ok && dq_full && !dq_pop) ovf_q <= 1'b1;
      if (dq_pop)  oq_wp_q <= oq_wp_q + 1'b1;
      if (oq_pop)  oq_rp_q <= oq_rp_q + 1'b1;
      oq_cnt_q <= oq_cnt_q + (QAW+1)'(dq_pop) - (QAW+1)'(oq_pop);
      if (pf_push) pf_wp_q <= pf_wp_q + 1'b1;
      if (pf_pop)  pf_rp_q <= pf_rp_q + 1'b1;
      pf_cnt_q <= pf_cnt_q + (FAW+1)'(pf_push) - (FAW+1)'(pf_pop);
      if (pf_pop) begin
        if (eol) begin
          col_q <= '0;
          row_q <= eof ? 16'd0 : row_q + 16'd1;
        end else begin
          col_q <= col_q + 16'd1;
        end
      end
    end
  end

  assign bus.read_addr     = addr_q;
  assign bus.read_len      = len_q;
  assign bus.read_size     = 3'(BSH);
  assign bus.read_burst    = 2'b01;
  assign bus.m_axis_tvalid = pf_cnt_q != '0;
  assign bus.m_axis_tdata  = bus.m_axis_tvalid ? pf_mem[pf_rp_q] : '0;
  assign bus.m_axis_tuser  = bus.m_axis_tvalid && (row_q == '0) && (col_q == '0);
  assign bus.m_axis_tlast  = bus.m_axis_tvalid && eol;
  assign busy           = (dq_cnt_q != '0) || (state_q != IDLE) || (pf_cnt_q != '0);
  assign queue_overflow = ovf_q;
  assign rlast_error    = rerr_q;
endmodule
